fifo_tx_serializer: RTL and testbench
=====================================

Name: fifo_tx_serializer

Overview:
- Downstream consumer of the byte FIFO. Dequeues one word at a time over the FIFO's valid/yumi handshake and transmits it on a single-wire, UART-style serial line.
- Frame format: start bit, WIDTH_P data bits LSB first, optional parity bit, stop bit.
- Sits between the FIFO's read port and the chip-level serial pin.

Parameters:
- WIDTH_P, 8, data word width in bits; matches the FIFO word width.
- CLKS_PER_BIT_P, 4, clock cycles per serial bit; legal values are 2 and above.

Ports:
- clk_i  input  1  rising-edge clock.
- reset_n_i  input  1  reset, active-low, synchronous. Reset is sampled at posedge clk_i.
- enable_i  input  1  permits new frames to start.
- valid_i  input  1  FIFO has a word available (connects to FIFO valid_o).
- data_i  input  WIDTH_P  FIFO head word (connects to FIFO data_o).
- yumi_o  output  1  dequeue pulse to FIFO (connects to FIFO yumi_i).
- tx_o  output  1  serial line; idle level is 1.
- busy_o  output  1  a frame is in progress.
- done_o  output  1  one-cycle pulse on the last cycle of a stop bit.

Behaviour:
- Reset (reset_n_i=0 at posedge):
  - Next state is IDLE; tx_o=1, busy_o=0, done_o=0, yumi_o=0.
  - Bit counter, baud counter and shift register are cleared.
  - Reset mid-frame aborts the frame; tx_o=1 from the cycle after reset is sampled, and no yumi is issued during reset.
- States: IDLE, START, DATA, (PARITY), STOP.
- tx_o per state: START drives 0, DATA drives shift_reg[0], STOP drives 1.
- Bit timing:
  - Each bit state lasts exactly CLKS_PER_BIT_P cycles.
  - The baud counter is $clog2(CLKS_PER_BIT_P) bits wide, counts 0..CLKS_PER_BIT_P-1, and clears on every state change.
- IDLE:
  - yumi_o = valid_i & enable_i, combinational and in the same cycle.
  - On yumi_o, data_i is latched into the shift register and the next state is START.
  - yumi_o is never high when valid_i is low.
- DATA:
  - Bit index counts 0..WIDTH_P-1. The shift register shifts right once at the end of each bit period.
  - After bit WIDTH_P-1, go to PARITY if enabled, otherwise STOP.
- STOP, last cycle:
  - done_o=1.
  - If valid_i & enable_i: yumi_o=1, latch data_i, next state is START. This gives back-to-back frames with no idle gap.
  - Otherwise next state is IDLE.
- busy_o=1 in every state except IDLE. It is a registered state decode.
- Frame length is (WIDTH_P+2)*CLKS_PER_BIT_P cycles, plus CLKS_PER_BIT_P when parity is compiled in.
- tx_o first goes low the cycle after the yumi_o cycle.
- enable_i deasserted mid-frame: the current frame completes normally; no new word is accepted until enable_i returns high.
- Changes on valid_i/data_i during a frame are ignored. The word is captured only at the yumi_o cycle.
- All outputs except yumi_o are registered.

Optional Feature:
- Macro: FIFO_TX_SERIALIZER_PARITY_EN.
- When defined:
  - A PARITY state of CLKS_PER_BIT_P cycles is inserted between DATA and STOP.
  - tx_o = even parity, i.e. XOR of the captured word, computed at capture time and held in a register.
- When undefined:
  - No PARITY state and no parity register.
  - DATA goes directly to STOP; frame is (WIDTH_P+2)*CLKS_PER_BIT_P cycles.

Test Plan:
- Reset then idle: reset_n_i=0 for 2 cycles, then valid_i=0, enable_i=1 for 20 cycles -> tx_o=1, yumi_o=0, busy_o=0 throughout.
- Single frame: valid_i=1, data_i=8'hA5 at cycle 0 ->
  - yumi_o=1 at cycle 0 only;
  - tx_o bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, cycles 1-40;
  - done_o at cycle 40; busy_o low at cycle 41.
- Back-to-back: FIFO holds 8'h00 then 8'hFF ->
  - second yumi_o coincides with the first frame's done_o (cycle 40);
  - tx_o=0 at cycle 41 with no idle gap;
  - second frame data bits are all 1.
- Enable gating: valid_i=1, enable_i=0 -> no yumi_o and tx_o=1. Raise enable_i, then drop it 5 cycles into the frame -> frame completes, then IDLE, no second yumi.
- Reset mid-frame: assert reset_n_i=0 during DATA bit 3 of 8'h0F -> tx_o=1 and busy_o=0 next cycle. After release, a new frame starts on valid_i.
- Parity, FIFO_TX_SERIALIZER_PARITY_EN defined:
  - 8'hA5 -> parity bit 0; 8'h07 -> parity bit 1;
  - frame length 44 cycles; done_o at cycle 44.

Source files
------------

// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer: dequeues words from a valid/yumi FIFO read port and
// transmits each one as a UART-style frame: start, WIDTH_P data bits LSB first,
// optional even parity, then stop.
// Parameters:
//   WIDTH_P        - data word width in bits
//   CLKS_PER_BIT_P - clock cycles per serial bit (2 or more)
// Ports:
//   clk_i     - rising-edge clock
//   reset_n_i - synchronous active-low reset
//   enable_i  - permits new frames to start
//   valid_i   - FIFO has a word available
//   data_i    - FIFO head word
//   yumi_o    - combinational dequeue pulse to the FIFO
//   tx_o      - registered serial line, idles high
//   busy_o    - registered, a frame is in progress
//   done_o    - registered, high on the last cycle of a stop bit
// Optional feature: define FIFO_TX_SERIALIZER_PARITY_EN to insert an even
// parity bit between the last data bit and the stop bit.
module fifo_tx_serializer #(
    parameter int WIDTH_P        = 8,
    parameter int CLKS_PER_BIT_P = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               enable_i,
    input  logic               valid_i,
    input  logic [WIDTH_P-1:0] data_i,
    output logic               yumi_o,
    output logic               tx_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int BAUD_W = (CLKS_PER_BIT_P > 1) ? $clog2(CLKS_PER_BIT_P) : 1;
    localparam int BIT_W  = (WIDTH_P > 1) ? $clog2(WIDTH_P) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT_P - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH_P - 1);

`ifdef FIFO_TX_SERIALIZER_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;
`endif

    state_e               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [WIDTH_P-1:0]   shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic yumi;
    logic bit_end;
    logic take;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif
        yumi     = 1'b0;
        take     = valid_i & enable_i;
        bit_end  = (baud_q == BAUD_LAST);

        // Baud counter wraps at the end of every bit; state changes only
        // happen on that wrap, so it is zero at the start of each state.
        if (bit_end) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (take) begin
                    yumi     = 1'b1;
                    state_d  = S_START;
                    shift_d  = data_i;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
                    parity_d = ^data_i;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Accepting here chains frames with no idle gap.
                if (bit_end) begin
                    if (take) begin
                        yumi     = 1'b1;
                        state_d  = S_START;
                        shift_d  = data_i;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
                        parity_d = ^data_i;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it.
        tx_d = 1'b1;
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);

        // The FIFO must never see a dequeue while reset is held.
        if (!reset_n_i) begin
            yumi = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign yumi_o = yumi;
    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// tb_fifo_tx_serializer: drives fifo_tx_serializer from a small FIFO model
// and decodes the serial line against a queue of expected words.
module tb_fifo_tx_serializer;

    localparam int W   = 8;
    localparam int CPB = 4;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB  = W + 2 + PAR;
    localparam int FL  = NB * CPB;

    logic         clk       = 1'b0;
    logic         reset_n_i = 1'b0;
    logic         enable_i  = 1'b1;
    logic         valid_i   = 1'b0;
    logic [W-1:0] data_i    = '0;
    logic         yumi_o;
    logic         tx_o;
    logic         busy_o;
    logic         done_o;

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] fifo[$];
    logic [W-1:0] exp_q[$];
    logic         yumi_seen = 1'b0;

    fifo_tx_serializer #(
        .WIDTH_P(W),
        .CLKS_PER_BIT_P(CPB)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n_i),
        .enable_i(enable_i),
        .valid_i(valid_i),
        .data_i(data_i),
        .yumi_o(yumi_o),
        .tx_o(tx_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [NB-1:0] frame_bits(input logic [W-1:0] d);
        logic [NB-1:0] f;
        f = '0;
        for (int i = 0; i < W; i++) f[1+i] = d[i];
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
        f[W+1] = ^d;
`endif
        f[NB-1] = 1'b1;
        return f;
    endfunction

    // FIFO model: head word presented on valid_i/data_i, popped on yumi.
    always @(negedge clk) yumi_seen = yumi_o;

    always @(posedge clk) begin
        #2;
        if (yumi_seen && fifo.size() > 0) fifo.delete(0);
        valid_i = (fifo.size() > 0);
        data_i  = (fifo.size() > 0) ? fifo[0] : '0;
    end

    // Monitor: decode frames from tx_o and score against exp_q.
    logic          in_frame = 1'b0;
    int            pos      = 0;
    logic [NB-1:0] bits;
    logic          glitch;
    logic          done_bad;

    always @(negedge clk) begin
        if (yumi_o) chk("yumi_needs_valid", valid_i, 1);
        if (!reset_n_i) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && tx_o == 1'b0) begin
                in_frame = 1'b1;
                pos      = 0;
                glitch   = 1'b0;
                done_bad = 1'b0;
                bits     = '0;
            end
            if (in_frame) begin
                if (pos % CPB == 0) bits[pos/CPB] = tx_o;
                else if (bits[pos/CPB] !== tx_o) glitch = 1'b1;
                if (done_o !== (pos == FL - 1)) done_bad = 1'b1;
                pos++;
                if (pos == FL) begin
                    in_frame = 1'b0;
                    chk("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        chk("frame_bits", bits, frame_bits(exp_q[0]));
                        exp_q.delete(0);
                    end
                    chk("frame_bit_width", glitch, 0);
                    chk("frame_done_pos", done_bad, 0);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [W-1:0] d);
        cyc();
        fifo.push_back(d);
        exp_q.push_back(d);
        @(negedge clk);
        chk("single_yumi_c0", yumi_o, 1);
        for (int c = 1; c <= FL + 1; c++) begin
            cyc();
            @(negedge clk);
            chk("single_yumi_low", yumi_o, 0);
            if (c == 1) chk("single_tx_start", tx_o, 0);
            if (c == 1) chk("single_busy", busy_o, 1);
            if (c == FL) chk("single_done", done_o, 1);
            if (c == FL + 1) chk("single_busy_end", busy_o, 0);
        end
    endtask

    initial begin
        // Reset then idle
        reset_n_i = 1'b0;
        enable_i  = 1'b1;
        cyc();
        @(negedge clk);
        chk("rst_tx", tx_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_yumi", yumi_o, 0);
        cyc();
        reset_n_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cyc();
            @(negedge clk);
            chk("idle_tx", tx_o, 1);
            chk("idle_yumi", yumi_o, 0);
            chk("idle_busy", busy_o, 0);
        end

        // Single frames
        send_one(8'hA5);
        send_one(8'h07);

        // Back-to-back: 00 then FF
        cyc();
        fifo.push_back(8'h00);
        fifo.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        @(negedge clk);
        chk("b2b_yumi_c0", yumi_o, 1);
        for (int c = 1; c <= 2 * FL + 1; c++) begin
            cyc();
            @(negedge clk);
            if (c == FL) chk("b2b_done1", done_o, 1);
            if (c == FL) chk("b2b_yumi2", yumi_o, 1);
            if (c != FL) chk("b2b_yumi_low", yumi_o, 0);
            if (c == FL + 1) chk("b2b_tx_nogap", tx_o, 0);
            if (c == FL + 1) chk("b2b_busy_nogap", busy_o, 1);
            if (c == 2 * FL) chk("b2b_done2", done_o, 1);
            if (c == 2 * FL + 1) chk("b2b_busy_end", busy_o, 0);
        end

        // Enable gating
        cyc();
        enable_i = 1'b0;
        fifo.push_back(8'h3C);
        fifo.push_back(8'h5A);
        for (int c = 0; c < 10; c++) begin
            cyc();
            @(negedge clk);
            chk("gate_yumi", yumi_o, 0);
            chk("gate_tx", tx_o, 1);
        end
        cyc();
        enable_i = 1'b1;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        chk("gate_yumi_on", yumi_o, 1);
        for (int c = 1; c <= FL + 10; c++) begin
            cyc();
            if (c == 5) enable_i = 1'b0;
            @(negedge clk);
            chk("gate_no_second_yumi", yumi_o, 0);
            if (c == FL) chk("gate_done", done_o, 1);
            if (c == FL + 1) chk("gate_busy_end", busy_o, 0);
            if (c == FL + 10) chk("gate_still_idle", busy_o, 0);
        end

        // Reset mid-frame during DATA bit 3 of 0F
        cyc();
        fifo.delete();
        fifo.push_back(8'h0F);
        enable_i = 1'b1;
        @(negedge clk);
        chk("mrst_yumi_c0", yumi_o, 1);
        for (int c = 1; c <= 20 + FL + 1; c++) begin
            cyc();
            if (c == 18) begin
                reset_n_i = 1'b0;
                fifo.push_back(8'h81);
            end
            if (c == 20) begin
                reset_n_i = 1'b1;
                exp_q.push_back(8'h81);
            end
            @(negedge clk);
            if (c == 16) chk("mrst_bit2", tx_o, 1);
            if (c == 18) chk("mrst_busy_before", busy_o, 1);
            if (c == 19) chk("mrst_tx_idle", tx_o, 1);
            if (c == 19) chk("mrst_busy_clear", busy_o, 0);
            if (c == 19) chk("mrst_no_yumi", yumi_o, 0);
            if (c == 20) chk("mrst_restart_yumi", yumi_o, 1);
            if (c == 21) chk("mrst_restart_tx", tx_o, 0);
            if (c == 20 + FL) chk("mrst_done", done_o, 1);
            if (c == 20 + FL + 1) chk("mrst_busy_end", busy_o, 0);
        end

        // Drain scoreboard
        for (int i = 0; i < 200 && (exp_q.size() != 0 || in_frame); i++)
            @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("monitor_idle", in_frame, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
